// File: rtl/mult_div_pkg.sv
// Shared constants and types for the multi-cycle signed multiply/divide unit.
// Both the Booth multiplier and the restoring divider run ITER single-bit steps.
package mult_div_pkg;

  localparam int          ITER    = 32;
  localparam int          CNT_W   = $clog2(ITER) + 1;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MULT   = 2'd1,
    ST_DIV    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step on unsigned magnitudes: trial-subtract the divisor
// from the shifted partial remainder and keep the difference only if it is non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_partial,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_diff;

  // The partial remainder is below twice the divisor, so the borrow sits in the top bit.
  assign w_diff  = i_partial - {1'b0, i_divisor};
  assign o_q_bit = ~w_diff[WIDTH];
  assign o_rem   = o_q_bit ? w_diff[WIDTH-1:0] : i_partial[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) and divide (restoring, on magnitudes)
// producing the HI/LO pair for the multicycle MIPS datapath.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multOP,
  input  logic             divOP,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divByZero
);

  state_t             r_state;
  state_t             w_state_next;
  op_t                r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH:0]   r_prod;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz_pend;
  logic               r_dbz;

  logic               w_load_mult;
  logic               w_load_div;
  logic               w_dbz_req;
  logic               w_last;
  logic [WIDTH:0]     w_acc;
  logic [WIDTH:0]     w_mc;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH:0]   w_prod_next;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_partial;
  logic [WIDTH-1:0]   w_rem_next;
  logic               w_q_bit;
  logic [WIDTH-1:0]   w_quo_res;
  logic [WIDTH-1:0]   w_rem_res;

  assign w_last = (r_cnt == CNT_W'(ITER - 1));

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_mult  = 1'b0;
    w_load_div   = 1'b0;
    w_dbz_req    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (multOP) begin
          w_load_mult  = 1'b1;
          w_state_next = ST_MULT;
        end else if (divOP) begin
          if (b != '0) begin
            w_load_div   = 1'b1;
            w_state_next = ST_DIV;
          end else begin
            w_dbz_req = 1'b1;
          end
        end
      end
      ST_MULT:   if (w_last) w_state_next = ST_FINISH;
      ST_DIV:    if (w_last) w_state_next = ST_FINISH;
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // ---------------- Booth step ----------------
  // One guard bit on the accumulator keeps A +/- M exact even for the most negative multiplicand.
  assign w_acc = {r_prod[2*WIDTH], r_prod[2*WIDTH:WIDTH+1]};
  assign w_mc  = {r_mcand[WIDTH-1], r_mcand};

  always_comb begin
    w_sum = w_acc;
    case (r_prod[1:0])
      2'b01:   w_sum = w_acc + w_mc;
      2'b10:   w_sum = w_acc - w_mc;
      default: w_sum = w_acc;
    endcase
  end

  assign w_prod_next = {w_sum, r_prod[WIDTH:1]};

  // ---------------- divide step and sign fix-up ----------------
  assign w_abs_a   = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign w_abs_b   = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign w_partial = {r_rem, r_quo[WIDTH-1]};

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .i_partial(w_partial),
    .i_divisor(r_divisor),
    .o_rem    (w_rem_next),
    .o_q_bit  (w_q_bit)
  );

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign w_quo_res = (r_sign_a ^ r_sign_b) ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_res = r_sign_a ? (~r_rem + 1'b1) : r_rem;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op       <= OP_MULT;
      r_cnt      <= '0;
      r_prod     <= '0;
      r_mcand    <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_divisor  <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_dbz_pend <= w_dbz_req;
      r_dbz      <= r_dbz_pend;
      if (w_load_mult) begin
        r_op    <= OP_MULT;
        r_mcand <= a;
        r_prod  <= {{WIDTH{1'b0}}, b, 1'b0};
        r_cnt   <= '0;
      end
      if (w_load_div) begin
        r_op      <= OP_DIV;
        r_sign_a  <= a[WIDTH-1];
        r_sign_b  <= b[WIDTH-1];
        r_quo     <= w_abs_a;
        r_divisor <= w_abs_b;
        r_rem     <= '0;
        r_cnt     <= '0;
      end
      case (r_state)
        ST_MULT: begin
          r_prod <= w_prod_next;
          r_cnt  <= r_cnt + 1'b1;
        end
        ST_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt + 1'b1;
        end
        ST_FINISH: begin
          r_cnt  <= '0;
          r_done <= 1'b1;
          if (r_op == OP_MULT) begin
            r_hi <= r_prod[2*WIDTH:WIDTH+1];
            r_lo <= r_prod[WIDTH:1];
          end else begin
            r_hi <= w_rem_res;
            r_lo <= w_quo_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state == ST_MULT) || (r_state == ST_DIV);
  assign done      = r_done;
  assign divByZero = r_dbz;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule
